// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port among NREQ requesters.
// Optional BUSY timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDXW    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_read,
  input  logic [NREQ*32-1:0] req_address,
  output logic [NREQ-1:0]   req_ack,
  output logic [31:0]       req_data,
  output logic              req_err,
  output logic              mem_read_o,
  output logic [31:0]       mem_address_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_Message_i,
  output logic              busy,
  output logic [IDXW-1:0]   grant_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            rd_q, rd_d;
  logic            busy_q, busy_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  logic            found;
  logic [IDXW-1:0] sel;
  logic [31:0]     sel_addr;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int k;
    found    = 1'b0;
    sel      = ptr_q;
    sel_addr = '0;
    k        = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_q) + i) % NREQ;
      if (!found && req_read[k]) begin
        found    = 1'b1;
        sel      = IDXW'(k);
        sel_addr = req_address[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = '0;
    rd_d    = rd_q;
    busy_d  = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_BUSY;
          grant_d = sel;
          addr_d  = sel_addr;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_BUSY: begin
        if (mem_ack_i) begin
          state_d        = S_RESP;
          data_d         = mem_Message_i;
          ack_d[grant_q] = 1'b1;
          rd_d           = 1'b0;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          state_d        = S_RESP;
          data_d         = '0;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          rd_d           = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ptr_d   = (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req_ack       = ack_q;
  assign req_data      = data_q;
  assign mem_read_o    = rd_q;
  assign mem_address_o = addr_q;
  assign busy          = busy_q;
  assign grant_idx     = grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign req_err       = err_q;
`else
  assign req_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of transactions
// plus hand-written reset, spurious-ack and timeout sequences.
module tb_mem_port_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_read;
  logic [NREQ*32-1:0] req_address;
  logic [NREQ-1:0]   req_ack;
  logic [31:0]       req_data;
  logic              req_err;
  logic              mem_read_o;
  logic [31:0]       mem_address_o;
  logic              mem_ack_i;
  logic [31:0]       mem_Message_i;
  logic              busy;
  logic [IDXW-1:0]   grant_idx;

  mem_port_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_address  (req_address),
    .req_ack      (req_ack),
    .req_data     (req_data),
    .req_err      (req_err),
    .mem_read_o   (mem_read_o),
    .mem_address_o(mem_address_o),
    .mem_ack_i    (mem_ack_i),
    .mem_Message_i(mem_Message_i),
    .busy         (busy),
    .grant_idx    (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  add;
    int          lat;
    logic [31:0] data;
    int          g;
  } vec_t;

  vec_t        vt[11];
  int          total = 0;
  int          pass  = 0;
  logic [3:0]  pend;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return 32'h80 + 32'h40 * i;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.g;
    pend = pend | v.add;
    req_read = pend;
    @(negedge clk);
    chk("grant_idx", 32'(grant_idx), 32'(v.g));
    chk("mem_addr", mem_address_o, addr_of(v.g));
    chk("mem_read_busy", 32'(mem_read_o), 32'd1);
    chk("busy", 32'(busy), 32'd1);
    chk("ack_busy", 32'(req_ack), 32'd0);
    repeat (v.lat - 1) @(negedge clk);
    mem_ack_i = 1'b1;
    mem_Message_i = v.data;
    @(negedge clk);
    mem_ack_i = 1'b0;
    mem_Message_i = 32'h0;
    chk("req_ack", 32'(req_ack), 32'(oh));
    chk("req_data", req_data, v.data);
    chk("req_err", 32'(req_err), 32'd0);
    chk("mem_read_resp", 32'(mem_read_o), 32'd0);
    pend = pend & ~oh;
    req_read = pend;
    @(negedge clk);
    chk("ack_idle", 32'(req_ack), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    vt[0]  = '{4'b1111, 1, 32'hA000_0000, 0};
    vt[1]  = '{4'b0000, 3, 32'hA111_1111, 1};
    vt[2]  = '{4'b0000, 1, 32'hA222_2222, 2};
    vt[3]  = '{4'b0000, 2, 32'hA333_3333, 3};
    vt[4]  = '{4'b1001, 1, 32'hB000_0004, 0};
    vt[5]  = '{4'b0000, 1, 32'hB000_0005, 3};
    vt[6]  = '{4'b0100, 2, 32'hDEAD_BEEF, 2};
    vt[7]  = '{4'b1010, 1, 32'hC000_0007, 3};
    vt[8]  = '{4'b0000, 2, 32'hC000_0008, 1};
    vt[9]  = '{4'b0011, 1, 32'hC000_0009, 0};
    vt[10] = '{4'b0000, 1, 32'h1234_5678, 1};

    rst = 1'b1;
    req_read = '0;
    mem_ack_i = 1'b0;
    mem_Message_i = '0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) req_address[32*i +: 32] = addr_of(i);
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_data", req_data, 32'd0);
    chk("rst_rd", 32'(mem_read_o), 32'd0);
    chk("rst_addr", mem_address_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // spurious ack while idle
    mem_ack_i = 1'b1;
    mem_Message_i = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk("spur_ack", 32'(req_ack), 32'd0);
    chk("spur_data", req_data, vt[10].data);
    chk("spur_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("spur_data2", req_data, vt[10].data);

    // address change while granted, then reset mid-transaction
    req_read = 4'b0100;
    @(negedge clk);
    chk("g2_grant", 32'(grant_idx), 32'd2);
    chk("g2_rd", 32'(mem_read_o), 32'd1);
    req_address[64 +: 32] = 32'h0000_FFF0;
    @(negedge clk);
    chk("addr_latched", mem_address_o, 32'h100);
    chk("addr_rd", 32'(mem_read_o), 32'd1);
    req_address[64 +: 32] = addr_of(2);
    rst = 1'b1;
    req_read = '0;
    @(negedge clk);
    chk("mrst_rd", 32'(mem_read_o), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_grant", 32'(grant_idx), 32'd0);
    rst = 1'b0;
    mem_ack_i = 1'b1;
    mem_Message_i = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk("late_ack", 32'(req_ack), 32'd0);
    chk("late_rd", 32'(mem_read_o), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    chk("late_data", req_data, 32'd0);
    @(negedge clk);
    chk("late_ack2", 32'(req_ack), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    req_read = 4'b0001;
    @(negedge clk);
    chk("to_rd1", 32'(mem_read_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("to_rd4", 32'(mem_read_o), 32'd1);
    chk("to_noack", 32'(req_ack), 32'd0);
    @(negedge clk);
    chk("to_ack", 32'(req_ack), 32'd1);
    chk("to_err", 32'(req_err), 32'd1);
    chk("to_data", req_data, 32'd0);
    chk("to_rd", 32'(mem_read_o), 32'd0);
    req_read = '0;
    @(negedge clk);
    chk("to_ack_clr", 32'(req_ack), 32'd0);
    chk("to_err_clr", 32'(req_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single data-memory read port of the CGRA tile among `NREQ` processing-element controllers. Each controller issues load requests on its own `mem_read`/`mem_address` pair and receives the returned word with a one-cycle acknowledge. The arbiter serializes requests, holding one outstanding transaction at a time to the memory port, and returns `mem_Message`-style data to the granted requester. It sits between the per-PE `controller` instances and the tile memory interface.

## Interface

Parameters:
- `NREQ`, 4: number of requesting controllers (2..8).
- `IDXW`, 2: width of requester index; must equal clog2(`NREQ`).
- `TIMEOUT`, 255: cycles to wait for `mem_ack_i` before aborting; used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_read`  in  NREQ  per-requester read request, level; bit i = controller i.
- `req_address`  in  NREQ*32  per-requester address; slice [32*i+31:32*i] belongs to requester i.
- `req_ack`  out  NREQ  one-cycle acknowledge to the granted requester.
- `req_data`  out  32  returned word; valid only while any `req_ack` bit is high.
- `req_err`  out  1  high with `req_ack` when the transaction timed out.
- `mem_read_o`  out  1  read strobe to memory; held high until `mem_ack_i`.
- `mem_address_o`  out  32  latched address of the granted request.
- `mem_ack_i`  in  1  memory acknowledge, one-cycle pulse.
- `mem_Message_i`  in  32  memory read data, valid with `mem_ack_i`.
- `busy`  out  1  high in BUSY or RESP.
- `grant_idx`  out  IDXW  index of the current or last granted requester.

## Operation

- FSM states: IDLE, BUSY, RESP. Round-robin pointer `ptr` (IDXW bits) gives the highest-priority requester.
- IDLE: if any `req_read` bit is set, select the first set bit scanning `ptr`, `ptr+1`, … wrapping modulo `NREQ`. Latch the index into `grant_idx` and the address into `mem_address_o`, then go to BUSY. With no requests, stay in IDLE.
- BUSY: `mem_read_o`=1. On `mem_ack_i`=1, latch `mem_Message_i` into the data register and go to RESP.
- RESP: `req_ack[grant_idx]`=1 and `req_data` = the latched word. Set `ptr` to `grant_idx+1`, wrapping `NREQ-1` to 0, then go to IDLE.
- Requests are sampled only in IDLE. A requester must deassert `req_read` in the cycle after it sees `req_ack`. Address changes while granted are ignored because the address is latched.
- `mem_ack_i` in IDLE or RESP is ignored and does not change data.
- `req_ack` is one-hot or zero. It is never asserted outside RESP.
- Reset values: state IDLE, `ptr`=0, `grant_idx`=0, `mem_read_o`=0, `mem_address_o`=0, `req_ack`=0, `req_data`=0, `req_err`=0, `busy`=0, timeout counter 0.
- Reset mid-transaction: the FSM returns to IDLE at the next edge and `mem_read_o` drops. A later `mem_ack_i` is ignored and no `req_ack` is issued.

## Timing

- All outputs are registered.
- If a request is seen in IDLE at edge n, `mem_read_o` goes high after edge n.
- If `mem_ack_i` is seen at edge m, `req_ack` is high for the single cycle after edge m.
- Minimum request-to-ack latency is 3 cycles when memory acks in the first BUSY cycle.
- Back-to-back throughput is one transaction per (memory latency + 2) cycles. One IDLE cycle follows each RESP.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,…,NREQ-1, starting from `ptr`.

## Configuration

- `MEM_ARB_TIMEOUT_EN` defined: a counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack_i`. When it reaches `TIMEOUT`, the FSM goes to RESP with `req_err`=1 and `req_data`=0, and `mem_read_o` drops. An ack arriving in that same cycle takes precedence, giving a normal response.
- Not defined: no counter. BUSY waits indefinitely and `req_err` is tied to 0.

## Test plan

- Single request: `req_read`=4'b0100 with address 0x100 and memory acking after 2 cycles with 0xDEADBEEF. Expect `mem_address_o`=0x100, `req_ack`=4'b0100 for 1 cycle, `req_data`=0xDEADBEEF, `grant_idx`=2.
- All four requesting continuously from reset, each dropping its request after its ack. Expect grant order 0,1,2,3, and `ptr` back at 0.
- Requesters 1 and 3 request right after a grant to requester 2. Expect requester 3 granted before 1.
- Spurious `mem_ack_i` pulse in IDLE. Expect no `req_ack` and `req_data` unchanged.
- `rst` asserted during BUSY, then `mem_ack_i` arrives 1 cycle later. Expect `mem_read_o`=0, no `req_ack`, and state IDLE.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=4 and memory never acking. Expect `req_ack` with `req_err`=1 and `req_data`=0 on the cycle after the 4th BUSY cycle.
